// File: rtl/buff_nn_to_ip.sv
// Return-path buffer: collects NN scores, tracks argmax, packs a class+scores
// byte frame and holds it for the UDP/IP transmit layer until acknowledged.
module buff_nn_to_ip #(
  parameter  int NUM_OUTPUTS   = 10,
  parameter  int DATA_WIDTH    = 18,
  localparam int TX_DATA_BYTES = 2 + 3 * NUM_OUTPUTS
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic signed [DATA_WIDTH-1:0]  R_DATA,
  input  logic                          R_EN,
  input  logic                          R_DONE,
  input  logic [0:31]                   DST_IP_ADDRESS_NN,
  input  logic [0:47]                   DST_MAC_ADDRESS_NN,
  input  logic [0:15]                   DST_UDP_PORT_NN,
  output logic [0:TX_DATA_BYTES*8-1]    DATA_FRAME_TX,
  output logic [0:31]                   DST_IP_ADDRESS_TX,
  output logic [0:47]                   DST_MAC_ADDRESS_TX,
  output logic [0:15]                   DST_UDP_PORT_TX,
  output logic                          FRAME_VALID,
  input  logic                          FRAME_ACK,
  output logic                          BUSY,
  output logic                          OVERFLOW
);

  typedef enum logic [1:0] {IDLE, COLLECT, FINALIZE, SEND} state_t;

  localparam logic [7:0] COUNT_MAX = 8'(NUM_OUTPUTS);

  state_t                       state;
  logic signed [DATA_WIDTH-1:0] scores [NUM_OUTPUTS];
  logic signed [DATA_WIDTH-1:0] max_val;
  logic [7:0]                   count;
  logic [7:0]                   max_idx;
  logic                         store_en;
  logic                         is_new_max;
  logic [0:TX_DATA_BYTES*8-1]   frame_next;

  // A sample is kept only while collecting and a free slot remains; the
  // first kept sample always seeds the maximum, later ones need strictly greater.
  always_comb begin
    store_en   = R_EN && ((state == IDLE) || ((state == COLLECT) && (count != COUNT_MAX)));
    is_new_max = (count == 8'd0) || (R_DATA > max_val);
  end

  always_comb begin
    frame_next       = '0;
    frame_next[0:7]  = (count == 8'd0) ? 8'hFF : max_idx;
    frame_next[8:15] = count;
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      frame_next[16 + 24*i +: 24] = 24'(scores[i]);
    end
  end

  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      state              <= IDLE;
      count              <= 8'd0;
      max_idx            <= 8'hFF;
      max_val            <= '0;
      for (int i = 0; i < NUM_OUTPUTS; i++) scores[i] <= '0;
      DATA_FRAME_TX      <= '0;
      DST_IP_ADDRESS_TX  <= '0;
      DST_MAC_ADDRESS_TX <= '0;
      DST_UDP_PORT_TX    <= '0;
      FRAME_VALID        <= 1'b0;
      BUSY               <= 1'b0;
      OVERFLOW           <= 1'b0;
    end else begin
      if (store_en) begin
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
          if (count == 8'(i)) scores[i] <= R_DATA;
        end
        count <= count + 8'd1;
        if (is_new_max) begin
          max_val <= R_DATA;
          max_idx <= count;
        end
      end

      case (state)
        IDLE: begin
          if (R_EN || R_DONE) begin
            state <= R_DONE ? FINALIZE : COLLECT;
            BUSY  <= 1'b1;
          end
        end
        COLLECT: begin
          if (R_EN && (count == COUNT_MAX)) OVERFLOW <= 1'b1;
          if (R_DONE) state <= FINALIZE;
        end
        FINALIZE: begin
          DATA_FRAME_TX      <= frame_next;
          DST_IP_ADDRESS_TX  <= DST_IP_ADDRESS_NN;
          DST_MAC_ADDRESS_TX <= DST_MAC_ADDRESS_NN;
          DST_UDP_PORT_TX    <= DST_UDP_PORT_NN;
          count              <= 8'd0;
          max_idx            <= 8'hFF;
          max_val            <= '0;
          for (int i = 0; i < NUM_OUTPUTS; i++) scores[i] <= '0;
          if (R_EN) OVERFLOW <= 1'b1;
          FRAME_VALID        <= 1'b1;
          state              <= SEND;
        end
        SEND: begin
          if (R_EN || R_DONE) OVERFLOW <= 1'b1;
          if (FRAME_ACK) begin
            FRAME_VALID <= 1'b0;
            BUSY        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_buff_nn_to_ip.sv
// Directed self-checking bench for buff_nn_to_ip: frame packing, argmax,
// latency, backpressure, overflow and asynchronous reset.
module tb_buff_nn_to_ip;

  localparam int NUM_OUTPUTS = 10;
  localparam int FRAME_BITS  = (2 + 3 * NUM_OUTPUTS) * 8;

  logic                     ACLK;
  logic                     ARESET;
  logic signed [17:0]       R_DATA;
  logic                     R_EN;
  logic                     R_DONE;
  logic [0:31]              DST_IP_ADDRESS_NN;
  logic [0:47]              DST_MAC_ADDRESS_NN;
  logic [0:15]              DST_UDP_PORT_NN;
  logic [0:FRAME_BITS-1]    DATA_FRAME_TX;
  logic [0:31]              DST_IP_ADDRESS_TX;
  logic [0:47]              DST_MAC_ADDRESS_TX;
  logic [0:15]              DST_UDP_PORT_TX;
  logic                     FRAME_VALID;
  logic                     FRAME_ACK;
  logic                     BUSY;
  logic                     OVERFLOW;

  logic signed [17:0] scoreVec [0:15];
  int assertCount = 0;
  int failCount   = 0;

  buff_nn_to_ip #(.NUM_OUTPUTS(NUM_OUTPUTS), .DATA_WIDTH(18)) dut (
    .ACLK               (ACLK),
    .ARESET             (ARESET),
    .R_DATA             (R_DATA),
    .R_EN               (R_EN),
    .R_DONE             (R_DONE),
    .DST_IP_ADDRESS_NN  (DST_IP_ADDRESS_NN),
    .DST_MAC_ADDRESS_NN (DST_MAC_ADDRESS_NN),
    .DST_UDP_PORT_NN    (DST_UDP_PORT_NN),
    .DATA_FRAME_TX      (DATA_FRAME_TX),
    .DST_IP_ADDRESS_TX  (DST_IP_ADDRESS_TX),
    .DST_MAC_ADDRESS_TX (DST_MAC_ADDRESS_TX),
    .DST_UDP_PORT_TX    (DST_UDP_PORT_TX),
    .FRAME_VALID        (FRAME_VALID),
    .FRAME_ACK          (FRAME_ACK),
    .BUSY               (BUSY),
    .OVERFLOW           (OVERFLOW)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  function automatic logic [63:0] frameByte(input int b);
    return 64'(DATA_FRAME_TX[8*b +: 8]);
  endfunction

  function automatic logic [63:0] scoreAt(input int i);
    return 64'(DATA_FRAME_TX[16 + 24*i +: 24]);
  endfunction

  // Drives n scores then R_DONE (or R_DONE with the last score); returns just
  // after the edge that sampled R_DONE.
  task automatic applyStimulus(input int n, input bit doneWithLast);
    for (int i = 0; i < n; i++) begin
      R_EN   = 1'b1;
      R_DATA = scoreVec[i];
      R_DONE = doneWithLast && (i == n - 1);
      tick();
    end
    if (!doneWithLast || n == 0) begin
      R_EN   = 1'b0;
      R_DONE = 1'b1;
      tick();
    end
    R_EN   = 1'b0;
    R_DONE = 1'b0;
    R_DATA = '0;
  endtask

  task automatic expectFrameLatency(input string tag);
    checkOutput({tag, "_valid_finalize"}, 64'(FRAME_VALID), 64'h0);
    tick();
    checkOutput({tag, "_valid_send"}, 64'(FRAME_VALID), 64'h1);
    checkOutput({tag, "_busy_send"}, 64'(BUSY), 64'h1);
  endtask

  task automatic ackFrame(input string tag);
    FRAME_ACK = 1'b1;
    tick();
    FRAME_ACK = 1'b0;
    checkOutput({tag, "_valid_after_ack"}, 64'(FRAME_VALID), 64'h0);
    checkOutput({tag, "_busy_after_ack"}, 64'(BUSY), 64'h0);
  endtask

  task automatic loadFirstVector();
    scoreVec[0] = 18'sd5;   scoreVec[1] = -18'sd3; scoreVec[2] = 18'sd20;
    scoreVec[3] = 18'sd7;   scoreVec[4] = 18'sd20; scoreVec[5] = 18'sd0;
    scoreVec[6] = 18'sd1;   scoreVec[7] = 18'sd2;  scoreVec[8] = -18'sd8;
    scoreVec[9] = 18'sd19;
  endtask

  task automatic runFirstVector(input string tag);
    loadFirstVector();
    applyStimulus(10, 1'b0);
    expectFrameLatency(tag);
    ackFrame(tag);
    checkOutput({tag, "_byte0"}, frameByte(0), 64'h02);
    checkOutput({tag, "_byte1"}, frameByte(1), 64'h0A);
    checkOutput({tag, "_score0"}, scoreAt(0), 64'h000005);
    checkOutput({tag, "_score1"}, scoreAt(1), 64'hFFFFFD);
    checkOutput({tag, "_score2"}, scoreAt(2), 64'h000014);
    checkOutput({tag, "_score8"}, scoreAt(8), 64'hFFFFF8);
    checkOutput({tag, "_score9"}, scoreAt(9), 64'h000013);
    checkOutput({tag, "_overflow"}, 64'(OVERFLOW), 64'h0);
  endtask

  initial begin
    bit sawValid;
    bit droppedValid;
    ARESET = 1'b0; R_DATA = '0; R_EN = 1'b0; R_DONE = 1'b0; FRAME_ACK = 1'b0;
    DST_IP_ADDRESS_NN  = 32'hC0A8_0105;
    DST_MAC_ADDRESS_NN = 48'h0200_DEAD_BEEF;
    DST_UDP_PORT_NN    = 16'h1F90;
    for (int i = 0; i < 16; i++) scoreVec[i] = '0;
    tick();
    tick();
    checkOutput("reset_valid", 64'(FRAME_VALID), 64'h0);
    checkOutput("reset_busy", 64'(BUSY), 64'h0);
    checkOutput("reset_overflow", 64'(OVERFLOW), 64'h0);
    checkOutput("reset_frame", 64'(|DATA_FRAME_TX), 64'h0);
    checkOutput("reset_dst_ip", 64'(DST_IP_ADDRESS_TX), 64'h0);
    ARESET = 1'b1;
    tick();

    // Mixed scores, tie at indices 2 and 4 resolves to the lower index.
    runFirstVector("t1");
    checkOutput("t1_dst_ip", 64'(DST_IP_ADDRESS_TX), 64'hC0A8_0105);
    checkOutput("t1_dst_mac", 64'(DST_MAC_ADDRESS_TX), 64'h0200_DEAD_BEEF);
    checkOutput("t1_dst_port", 64'(DST_UDP_PORT_TX), 64'h1F90);

    // All negative: largest is -91 at index 9.
    for (int i = 0; i < 10; i++) scoreVec[i] = 18'(-100 + i);
    applyStimulus(10, 1'b0);
    expectFrameLatency("t2");
    ackFrame("t2");
    checkOutput("t2_byte0", frameByte(0), 64'h09);
    checkOutput("t2_byte1", frameByte(1), 64'h0A);
    checkOutput("t2_score0", scoreAt(0), 64'hFFFF9C);
    checkOutput("t2_score9", scoreAt(9), 64'hFFFFA5);

    // R_DONE with no scores still emits a frame.
    applyStimulus(0, 1'b0);
    expectFrameLatency("t5");
    ackFrame("t5");
    checkOutput("t5_byte0", frameByte(0), 64'hFF);
    checkOutput("t5_byte1", frameByte(1), 64'h00);
    checkOutput("t5_score0", scoreAt(0), 64'h000000);
    checkOutput("t5_overflow", 64'(OVERFLOW), 64'h0);

    // Backpressure with extreme values; DST inputs and R_EN disturbed during SEND.
    DST_IP_ADDRESS_NN  = 32'h0A00_0001;
    DST_MAC_ADDRESS_NN = 48'h1122_3344_5566;
    DST_UDP_PORT_NN    = 16'h0050;
    scoreVec[0] = 18'sh20000; scoreVec[1] = 18'sd100; scoreVec[2] = 18'sh1FFFF;
    applyStimulus(3, 1'b0);
    expectFrameLatency("t3");
    droppedValid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c == 1) begin
        DST_IP_ADDRESS_NN  = 32'hFFFF_FFFF;
        DST_MAC_ADDRESS_NN = 48'hFFFF_FFFF_FFFF;
        DST_UDP_PORT_NN    = 16'hFFFF;
        R_EN   = 1'b1;
        R_DATA = 18'sd77;
      end else begin
        R_EN = 1'b0;
      end
      tick();
      if (!FRAME_VALID) droppedValid = 1'b1;
    end
    R_EN = 1'b0;
    checkOutput("t3_valid_held", 64'(droppedValid), 64'h0);
    checkOutput("t3_busy_held", 64'(BUSY), 64'h1);
    checkOutput("t3_overflow", 64'(OVERFLOW), 64'h1);
    checkOutput("t3_byte0", frameByte(0), 64'h02);
    checkOutput("t3_byte1", frameByte(1), 64'h03);
    checkOutput("t3_score0_min", scoreAt(0), 64'hFE0000);
    checkOutput("t3_score2_max", scoreAt(2), 64'h01FFFF);
    checkOutput("t3_dst_ip", 64'(DST_IP_ADDRESS_TX), 64'h0A00_0001);
    checkOutput("t3_dst_mac", 64'(DST_MAC_ADDRESS_TX), 64'h1122_3344_5566);
    checkOutput("t3_dst_port", 64'(DST_UDP_PORT_TX), 64'h0050);
    ackFrame("t3");
    checkOutput("t3_byte0_hold", frameByte(0), 64'h02);

    // Asynchronous reset in the middle of collecting.
    for (int i = 0; i < 5; i++) begin
      R_EN   = 1'b1;
      R_DATA = 18'(i + 1);
      tick();
    end
    R_EN = 1'b0;
    #2;
    ARESET = 1'b0;
    #1;
    checkOutput("t6_async_valid", 64'(FRAME_VALID), 64'h0);
    checkOutput("t6_async_busy", 64'(BUSY), 64'h0);
    checkOutput("t6_async_overflow", 64'(OVERFLOW), 64'h0);
    checkOutput("t6_async_frame", 64'(|DATA_FRAME_TX), 64'h0);
    checkOutput("t6_async_dst_ip", 64'(DST_IP_ADDRESS_TX), 64'h0);
    tick();
    ARESET = 1'b1;
    sawValid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (FRAME_VALID) sawValid = 1'b1;
    end
    checkOutput("t6_no_frame", 64'(sawValid), 64'h0);
    DST_IP_ADDRESS_NN  = 32'hC0A8_0105;
    DST_MAC_ADDRESS_NN = 48'h0200_DEAD_BEEF;
    DST_UDP_PORT_NN    = 16'h1F90;
    runFirstVector("t6_full");

    // Twelve scores: only ten kept.
    for (int i = 0; i < 12; i++) scoreVec[i] = 18'(i * 10);
    applyStimulus(12, 1'b0);
    expectFrameLatency("t4");
    ackFrame("t4");
    checkOutput("t4_byte0", frameByte(0), 64'h09);
    checkOutput("t4_byte1", frameByte(1), 64'h0A);
    checkOutput("t4_score9", scoreAt(9), 64'h00005A);
    checkOutput("t4_overflow", 64'(OVERFLOW), 64'h1);

    // Short run, R_DONE coincident with the fourth score.
    scoreVec[0] = 18'sd3; scoreVec[1] = 18'sd9; scoreVec[2] = 18'sd9; scoreVec[3] = -18'sd2;
    applyStimulus(4, 1'b1);
    expectFrameLatency("t4s");
    ackFrame("t4s");
    checkOutput("t4s_byte0", frameByte(0), 64'h01);
    checkOutput("t4s_byte1", frameByte(1), 64'h04);
    checkOutput("t4s_score3", scoreAt(3), 64'hFFFFFE);
    for (int i = 4; i < NUM_OUTPUTS; i++) begin
      checkOutput($sformatf("t4s_empty_slot%0d", i), scoreAt(i), 64'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/buff_nn_to_ip.md
Name: buff_nn_to_ip

Overview:
Return-path buffer between the NN inference core and the UDP/IP transmit layer. It collects the NN output scores as a write-enable stream, tracks the running argmax, and packs the class and all scores into one fixed-size byte frame. It latches the destination IP/MAC/UDP port from the request-side buffer. It holds the frame with FRAME_VALID until the IP layer acknowledges with FRAME_ACK.

Parameters:
NUM_OUTPUTS, 10, number of score words per inference (1..255)
DATA_WIDTH, 18, signed score width (fixed to 18 by the NN core; must be <=24)
TX_DATA_BYTES, 2+3*NUM_OUTPUTS (=32), frame length in bytes; derived, not overridable

Ports:
ACLK  in  1  clock
ARESET  in  1  reset; asynchronous, active-low
R_DATA  in  DATA_WIDTH  signed two's-complement score from NN
R_EN  in  1  R_DATA valid this cycle
R_DONE  in  1  last score delivered (may coincide with R_EN)
DST_IP_ADDRESS_NN  in  [0:31]  requester IP from buff_ip_to_nn
DST_MAC_ADDRESS_NN  in  [0:47]  requester MAC
DST_UDP_PORT_NN  in  [0:15]  requester UDP port
DATA_FRAME_TX  out  [0:TX_DATA_BYTES*8-1]  packed response frame, byte 0 at MSBs [0:7]
DST_IP_ADDRESS_TX  out  [0:31]  latched destination IP
DST_MAC_ADDRESS_TX  out  [0:47]  latched destination MAC
DST_UDP_PORT_TX  out  [0:15]  latched destination port
FRAME_VALID  out  1  frame ready for transmit
FRAME_ACK  in  1  IP layer accepted the frame
BUSY  out  1  high in any state other than IDLE
OVERFLOW  out  1  sticky; results dropped (extra scores or scores during SEND)

Behaviour:
- Reset (ARESET=0, any state): state=IDLE; all outputs, frame, address registers, counters = 0; class register = 8'hFF. Reset mid-operation aborts the inference and does not emit a frame.
- States: IDLE, COLLECT, FINALIZE, SEND. All outputs are registered.
- IDLE: on R_EN or R_DONE, go to COLLECT. The same-cycle R_EN sample is stored. If R_DONE is also high, go to FINALIZE instead.
- COLLECT: each R_EN stores R_DATA at score slot idx=count and increments count.
  - When count == NUM_OUTPUTS, R_EN drops the sample and sets OVERFLOW.
  - On R_DONE, go to FINALIZE. An R_EN in the same cycle is stored first.
- Argmax, updated on every stored sample:
  - Signed compare; strict greater-than, so ties keep the lowest index.
  - The first stored sample always initializes the maximum.
- FINALIZE (1 cycle):
  - Build the frame. Byte 0 = argmax index; 8'hFF if count==0. Byte 1 = count.
  - Bytes 2+3i..4+3i = score i, sign-extended to 24 bits, big-endian. Unfilled slots = 0.
  - Latch DST_*_NN into DST_*_TX.
  - Clear count, argmax and score slots. Go to SEND.
- SEND: FRAME_VALID=1. DATA_FRAME_TX and DST_*_TX are stable.
  - On FRAME_ACK, go to IDLE; FRAME_VALID=0 from the next cycle.
  - FRAME_ACK outside SEND is ignored.
  - R_EN/R_DONE in SEND are dropped and set OVERFLOW.
- Latency: R_DONE sampled at edge k gives FINALIZE after k, and FRAME_VALID=1 after edge k+1. An ACK sampled at the first SEND edge yields a single-cycle FRAME_VALID.
- Frame outputs hold their last value after SEND until the next FINALIZE overwrites them.
- OVERFLOW clears only on reset.
- BUSY = (state != IDLE).

Test Plan:
- 10 R_EN scores {5,-3,20,7,20,0,1,2,-8,19}, then R_DONE, ACK 1 cycle later -> byte0=8'h02 (tie keeps index 2), byte1=8'h0A, score0 bytes 00 00 05, score1 bytes FF FF FD; FRAME_VALID rises 2 cycles after R_DONE and is high 1 cycle; OVERFLOW=0.
- All scores negative (-100..-91 on indices 0..9) -> byte0=8'h09; score 18'h20000 (min) encodes as FE 00 00.
- Backpressure: FRAME_ACK held low 6 cycles, then DST_* inputs change and R_EN pulses during SEND -> frame and DST_*_TX unchanged, FRAME_VALID high until ACK, OVERFLOW=1, BUSY=0 one cycle after the ACK edge.
- 12 R_EN before R_DONE -> only the first 10 stored, byte1=8'h0A, OVERFLOW=1. Then a short run of 4 scores with R_DONE coincident with the 4th R_EN -> byte1=8'h04, bytes 14..31 = 0.
- R_DONE with no R_EN -> byte0=8'hFF, byte1=8'h00, frame still sent.
- ARESET low mid-COLLECT after 5 scores -> all outputs 0 asynchronously, FRAME_VALID never asserts; next full inference produces a correct frame.
